// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, IF/ID register, stall/redirect handling
// and a RUN/DRAIN/HALT machine. Define IF_PERF_CNT_EN to build the perf counters.
module if_stage #(
    parameter int              PC_W      = 9,
    parameter int              INS_W     = 32,
    parameter logic [PC_W-1:0] RESET_PC  = '0,
    parameter int              DRAIN_CYC = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             redirect,
    input  logic [PC_W-1:0]  redirect_pc,
    output logic [PC_W-1:0]  imem_addr,
    input  logic [INS_W-1:0] imem_rdata,
    output logic [PC_W-1:0]  id_pc,
    output logic [INS_W-1:0] id_instr,
    output logic [6:0]       id_opcode,
    output logic             id_valid,
    output logic             halted,
    output logic [31:0]      perf_fetched,
    output logic [31:0]      perf_bubbles
);

    // Bubbles carry addi x0,x0,0 so a flushed slot never decodes as HALT (opcode 0).
    localparam logic [INS_W-1:0] NOP = INS_W'(32'h0000_0013);

    typedef enum logic [1:0] {S_RUN, S_DRAIN, S_HALT} state_t;

    state_t            state_q, state_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [PC_W-1:0]   id_pc_q, id_pc_d;
    logic [INS_W-1:0]  id_instr_q, id_instr_d;
    logic              id_valid_q, id_valid_d;
    logic              id_load;
    logic [3:0]        cnt_inc;

    assign cnt_inc = cnt_q + 4'd1;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        cnt_d      = cnt_q;
        id_load    = 1'b0;
        id_pc_d    = id_pc_q;
        id_instr_d = NOP;
        id_valid_d = 1'b0;
        case (state_q)
            S_RUN: begin
                if (redirect) begin
                    pc_d    = redirect_pc;
                    id_load = 1'b1;
                end else if (!stall) begin
                    id_load    = 1'b1;
                    id_pc_d    = pc_q;
                    id_instr_d = imem_rdata;
                    id_valid_d = 1'b1;
                    if (imem_rdata[6:0] == 7'd0) begin
                        state_d = S_DRAIN;
                        cnt_d   = 4'd0;
                    end else begin
                        pc_d = pc_q + PC_W'(4);
                    end
                end
            end
            S_DRAIN: begin
                // A redirect here means the HALT was fetched down a wrong path.
                if (redirect) begin
                    pc_d    = redirect_pc;
                    id_load = 1'b1;
                    cnt_d   = 4'd0;
                    state_d = S_RUN;
                end else if (!stall) begin
                    id_load = 1'b1;
                    cnt_d   = cnt_inc;
                    if (cnt_inc == 4'(DRAIN_CYC)) begin
                        state_d = S_HALT;
                    end
                end
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_RUN;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_RUN;
            pc_q       <= RESET_PC;
            cnt_q      <= 4'd0;
            id_pc_q    <= '0;
            id_instr_q <= NOP;
            id_valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
            if (id_load) begin
                id_pc_q    <= id_pc_d;
                id_instr_q <= id_instr_d;
                id_valid_q <= id_valid_d;
            end
        end
    end

    assign imem_addr = pc_q;
    assign id_pc     = id_pc_q;
    assign id_instr  = id_instr_q;
    assign id_opcode = id_instr_q[6:0];
    assign id_valid  = id_valid_q;
    assign halted    = (state_q == S_HALT);

`ifdef IF_PERF_CNT_EN
    logic [31:0] fetched_q, bubbles_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            fetched_q <= '0;
            bubbles_q <= '0;
        end else if (id_load) begin
            if (id_valid_d) fetched_q <= fetched_q + 32'd1;
            else            bubbles_q <= bubbles_q + 32'd1;
        end
    end

    assign perf_fetched = fetched_q;
    assign perf_bubbles = bubbles_q;
`else
    assign perf_fetched = '0;
    assign perf_bubbles = '0;
`endif

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed vector table, hand-written corner sequences and
// randomized traffic against a behavioural fetch model.
module tb_if_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam int          DRAIN = 4;

    logic        clk = 1'b0;
    logic        reset, stall, redirect;
    logic [8:0]  redirect_pc;
    logic [8:0]  imem_addr;
    logic [31:0] imem_rdata;
    logic [8:0]  id_pc;
    logic [31:0] id_instr;
    logic [6:0]  id_opcode;
    logic        id_valid, halted;
    logic [31:0] perf_fetched, perf_bubbles;

    logic [31:0] mem [0:127];

    int checks = 0;
    int errors = 0;

    if_stage dut (
        .clk(clk), .reset(reset), .stall(stall), .redirect(redirect),
        .redirect_pc(redirect_pc), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .id_pc(id_pc), .id_instr(id_instr), .id_opcode(id_opcode),
        .id_valid(id_valid), .halted(halted),
        .perf_fetched(perf_fetched), .perf_bubbles(perf_bubbles)
    );

    always #5 clk = ~clk;

    assign imem_rdata = mem[imem_addr[8:2]];

    // ---------------- helpers ----------------
    function automatic logic [31:0] addi_word(input int w);
        return {12'(w), 5'd1, 3'd0, 5'd1, 7'h13};
    endfunction

    function automatic logic [31:0] perf_exp(input int v);
`ifdef IF_PERF_CNT_EN
        return 32'(v);
`else
        return 32'd0 + 32'(v * 0);
`endif
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic step(input logic rst, input logic st, input logic rd, input logic [8:0] rpc);
        reset       = rst;
        stall       = st;
        redirect    = rd;
        redirect_pc = rpc;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_addr"},    32'(imem_addr), 32'h0);
        chk({tag, "_id_pc"},   32'(id_pc), 32'h0);
        chk({tag, "_instr"},   id_instr, NOP);
        chk({tag, "_valid"},   32'(id_valid), 32'h0);
        chk({tag, "_halted"},  32'(halted), 32'h0);
        chk({tag, "_fetched"}, perf_fetched, 32'h0);
        chk({tag, "_bubbles"}, perf_bubbles, 32'h0);
    endtask

    // ---------------- behavioural model ----------------
    logic [8:0]  m_pc, m_id_pc;
    logic [31:0] m_instr;
    logic        m_valid, m_halted;
    int          m_left;      // bubbles still owed after a HALT; -1 while running
    int          m_fetched, m_bubbles;

    task automatic model_step(input logic rst, input logic st, input logic rd, input logic [8:0] rpc);
        logic [31:0] w;
        if (rst) begin
            m_pc = 9'd0; m_id_pc = 9'd0; m_instr = NOP; m_valid = 1'b0;
            m_halted = 1'b0; m_left = -1; m_fetched = 0; m_bubbles = 0;
        end else if (m_halted) begin
            // frozen until reset
        end else if (rd) begin
            m_pc = rpc; m_instr = NOP; m_valid = 1'b0; m_left = -1; m_bubbles++;
        end else if (st) begin
            // everything holds
        end else if (m_left >= 0) begin
            m_instr = NOP; m_valid = 1'b0; m_bubbles++; m_left--;
            if (m_left == 0) m_halted = 1'b1;
        end else begin
            w = mem[m_pc >> 2];
            m_id_pc = m_pc; m_instr = w; m_valid = 1'b1; m_fetched++;
            if (w[6:0] == 7'd0) m_left = DRAIN;
            else m_pc = 9'((int'(m_pc) + 4) % 512);
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic        st;
        logic        rd;
        logic [8:0]  rpc;
        logic [8:0]  addr;
        logic [8:0]  pc;
        logic [31:0] instr;
        logic        v;
        logic        h;
        int          f;
        int          b;
    } vec_t;

    vec_t tbl [17];

    function automatic vec_t mk(input logic st, input logic rd, input logic [8:0] rpc,
                                input logic [8:0] addr, input logic [8:0] pc,
                                input logic [31:0] instr, input logic v, input logic h,
                                input int f, input int b);
        vec_t r;
        r.st = st; r.rd = rd; r.rpc = rpc; r.addr = addr; r.pc = pc;
        r.instr = instr; r.v = v; r.h = h; r.f = f; r.b = b;
        return r;
    endfunction

    initial begin
        logic [8:0] rpc;
        logic       r_rst, r_st, r_rd;
        int         halt_age;

        for (int i = 0; i < 128; i++) mem[i] = addi_word(i);
        mem[3] = 32'h0000_0000;   // HALT at 0x0C

        //              st   rd   rpc     addr    pc      instr          v  h  f  b
        tbl[0]  = mk(1'b0, 1'b0, 9'h000, 9'h004, 9'h000, addi_word(0),  1, 0, 1, 0);
        tbl[1]  = mk(1'b0, 1'b0, 9'h000, 9'h008, 9'h004, addi_word(1),  1, 0, 2, 0);
        tbl[2]  = mk(1'b1, 1'b0, 9'h000, 9'h008, 9'h004, addi_word(1),  1, 0, 2, 0);
        tbl[3]  = mk(1'b1, 1'b0, 9'h000, 9'h008, 9'h004, addi_word(1),  1, 0, 2, 0);
        tbl[4]  = mk(1'b0, 1'b0, 9'h000, 9'h00C, 9'h008, addi_word(2),  1, 0, 3, 0);
        tbl[5]  = mk(1'b1, 1'b1, 9'h040, 9'h040, 9'h008, NOP,           0, 0, 3, 1);
        tbl[6]  = mk(1'b0, 1'b0, 9'h000, 9'h044, 9'h040, addi_word(16), 1, 0, 4, 1);
        tbl[7]  = mk(1'b0, 1'b1, 9'h00C, 9'h00C, 9'h040, NOP,           0, 0, 4, 2);
        tbl[8]  = mk(1'b0, 1'b0, 9'h000, 9'h00C, 9'h00C, 32'h0,         1, 0, 5, 2);
        tbl[9]  = mk(1'b0, 1'b0, 9'h000, 9'h00C, 9'h00C, NOP,           0, 0, 5, 3);
        tbl[10] = mk(1'b1, 1'b0, 9'h000, 9'h00C, 9'h00C, NOP,           0, 0, 5, 3);
        tbl[11] = mk(1'b0, 1'b0, 9'h000, 9'h00C, 9'h00C, NOP,           0, 0, 5, 4);
        tbl[12] = mk(1'b0, 1'b0, 9'h000, 9'h00C, 9'h00C, NOP,           0, 0, 5, 5);
        tbl[13] = mk(1'b0, 1'b0, 9'h000, 9'h00C, 9'h00C, NOP,           0, 1, 5, 6);
        tbl[14] = mk(1'b1, 1'b1, 9'h080, 9'h00C, 9'h00C, NOP,           0, 1, 5, 6);
        tbl[15] = mk(1'b0, 1'b1, 9'h080, 9'h00C, 9'h00C, NOP,           0, 1, 5, 6);
        tbl[16] = mk(1'b0, 1'b0, 9'h000, 9'h00C, 9'h00C, NOP,           0, 1, 5, 6);

        // Reset and directed table
        step(1'b1, 1'b0, 1'b0, 9'h0);
        step(1'b1, 1'b0, 1'b0, 9'h0);
        chk_reset_vals("reset");
        for (int i = 0; i < 17; i++) begin
            step(1'b0, tbl[i].st, tbl[i].rd, tbl[i].rpc);
            chk($sformatf("vec%0d_addr", i),    32'(imem_addr), 32'(tbl[i].addr));
            chk($sformatf("vec%0d_id_pc", i),   32'(id_pc), 32'(tbl[i].pc));
            chk($sformatf("vec%0d_instr", i),   id_instr, tbl[i].instr);
            chk($sformatf("vec%0d_opcode", i),  32'(id_opcode), 32'(tbl[i].instr[6:0]));
            chk($sformatf("vec%0d_valid", i),   32'(id_valid), 32'(tbl[i].v));
            chk($sformatf("vec%0d_halted", i),  32'(halted), 32'(tbl[i].h));
            chk($sformatf("vec%0d_fetched", i), perf_fetched, perf_exp(tbl[i].f));
            chk($sformatf("vec%0d_bubbles", i), perf_bubbles, perf_exp(tbl[i].b));
        end

        // Reset while halted, with redirect and stall also high
        step(1'b1, 1'b1, 1'b1, 9'h080);
        chk_reset_vals("halt_reset");

        // Wrong-path HALT: redirect during DRAIN returns to RUN
        step(1'b0, 1'b0, 1'b0, 9'h0);
        step(1'b0, 1'b0, 1'b0, 9'h0);
        step(1'b0, 1'b0, 1'b0, 9'h0);
        chk("wp_pc8", 32'(id_pc), 32'h008);
        step(1'b0, 1'b0, 1'b0, 9'h0);
        chk("wp_halt_in_id", 32'(id_opcode), 32'h0);
        chk("wp_halt_valid", 32'(id_valid), 32'h1);
        step(1'b0, 1'b0, 1'b0, 9'h0);
        chk("wp_drain_bubble", 32'(id_valid), 32'h0);
        step(1'b0, 1'b0, 1'b1, 9'h020);
        chk("wp_redir_addr", 32'(imem_addr), 32'h020);
        chk("wp_redir_bubble", id_instr, NOP);
        step(1'b0, 1'b0, 1'b0, 9'h0);
        chk("wp_target_pc", 32'(id_pc), 32'h020);
        chk("wp_target_valid", 32'(id_valid), 32'h1);
        chk("wp_next_addr", 32'(imem_addr), 32'h024);
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 1'b0, 1'b0, 9'h0);
            chk($sformatf("wp_nohalt%0d", i), 32'(halted), 32'h0);
            chk($sformatf("wp_seq_pc%0d", i), 32'(id_pc), 32'(9'h024 + 9'(4 * i)));
        end

        // PC wrap at 2^PC_W-4
        step(1'b0, 1'b0, 1'b1, 9'h1FC);
        chk("wrap_redir_addr", 32'(imem_addr), 32'h1FC);
        step(1'b0, 1'b0, 1'b0, 9'h0);
        chk("wrap_id_pc", 32'(id_pc), 32'h1FC);
        chk("wrap_addr", 32'(imem_addr), 32'h000);
        step(1'b0, 1'b0, 1'b0, 9'h0);
        chk("wrap_id_pc0", 32'(id_pc), 32'h000);
        chk("wrap_addr4", 32'(imem_addr), 32'h004);

        // Randomized traffic against the model
        for (int i = 0; i < 128; i++) begin
            mem[i] = $urandom();
            mem[i][6:0] = ($urandom_range(0, 11) == 0) ? 7'h00 : 7'h13;
        end
        step(1'b1, 1'b0, 1'b0, 9'h0);
        model_step(1'b1, 1'b0, 1'b0, 9'h0);
        halt_age = 0;
        for (int c = 0; c < 3000; c++) begin
            r_rst = ($urandom_range(0, 149) == 0) || (halt_age > 6);
            r_st  = ($urandom_range(0, 3) == 0);
            r_rd  = ($urandom_range(0, 9) == 0);
            rpc   = ($urandom_range(0, 7) == 0) ? 9'($urandom_range(0, 511))
                                                : {7'($urandom_range(0, 127)), 2'b00};
            model_step(r_rst, r_st, r_rd, rpc);
            step(r_rst, r_st, r_rd, rpc);
            halt_age = m_halted ? halt_age + 1 : 0;
            chk("rnd_addr",    32'(imem_addr), 32'(m_pc));
            chk("rnd_id_pc",   32'(id_pc), 32'(m_id_pc));
            chk("rnd_instr",   id_instr, m_instr);
            chk("rnd_opcode",  32'(id_opcode), 32'(m_instr[6:0]));
            chk("rnd_valid",   32'(id_valid), 32'(m_valid));
            chk("rnd_halted",  32'(halted), 32'(m_halted));
            chk("rnd_fetched", perf_fetched, perf_exp(m_fetched));
            chk("rnd_bubbles", perf_bubbles, perf_exp(m_bubbles));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
